// File: rtl/aq_freq_meas_sched.sv
// aq_freq_meas_sched
// Round-robin scheduler that shares one frequency-counter engine among NUM_CH
// requesters. For each granted channel it selects the channel clock at the
// engine, clears the counter for CLR_CYC cycles, opens the count gate for
// exactly WINDOW cycles, then waits up to TIMEOUT cycles for the engine's
// (already synchronised) ENG_DONE and returns the count to the requester.
//
// Optional build macro: FREQ_AUTO_SCAN_EN adds the AUTO_EN input. While it is
// high, every channel counts as pending at arbitration time, so the block
// scans continuously. ACK is pulsed only for channels that really requested.
//
// Ports (all on ACLK, ARESETN asynchronous active-low):
//   REQ[NUM_CH]       per-channel request pulse
//   ACK[NUM_CH]       per-channel completion pulse
//   RESULT[32]        measured count (all ones on timeout)
//   RESULT_CH[CH_W]   channel the result belongs to
//   RESULT_ERR        result came from a timeout
//   RESULT_VALID      one-cycle result strobe
//   BUSY              a measurement is in progress
//   ENG_SEL[CH_W]     engine clock-mux select
//   ENG_CLR           engine counter clear
//   ENG_GATE          engine count enable
//   ENG_DONE          engine result-stable pulse
//   ENG_COUNT[32]     engine count, sampled with ENG_DONE
//   AUTO_EN           continuous scan enable (FREQ_AUTO_SCAN_EN builds only)
module aq_freq_meas_sched #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int WINDOW  = 100000000,
  parameter int CLR_CYC = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [NUM_CH-1:0] REQ,
  output logic [NUM_CH-1:0] ACK,
  output logic [31:0]       RESULT,
  output logic [CH_W-1:0]   RESULT_CH,
  output logic              RESULT_ERR,
  output logic              RESULT_VALID,
  output logic              BUSY,
  output logic [CH_W-1:0]   ENG_SEL,
  output logic              ENG_CLR,
  output logic              ENG_GATE,
  input  logic              ENG_DONE,
  input  logic [31:0]       ENG_COUNT
`ifdef FREQ_AUTO_SCAN_EN
  ,
  input  logic              AUTO_EN
`endif
);

  // Counters load N-1 and run down to 0, so each only needs to hold N-1.
  localparam int GW = $clog2(WINDOW);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CLR_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   cur_ch;
  logic [CW-1:0]     clr_cnt;
  logic [GW-1:0]     gate_cnt;
  logic [TW-1:0]     to_cnt;

  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] cur_onehot;
  logic              win_found;
  logic [CH_W-1:0]   win_ch;

`ifdef FREQ_AUTO_SCAN_EN
  assign cand = pending | {NUM_CH{AUTO_EN}};
`else
  assign cand = pending;
`endif

  assign cur_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << cur_ch;
  assign BUSY       = (state != S_IDLE);

  function automatic logic [CH_W-1:0] wrap_idx(input int v);
    return CH_W'(v % NUM_CH);
  endfunction

  // Walk from the farthest candidate back to rr_ptr+1 so the closest
  // pending channel after rr_ptr is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (cand[wrap_idx(int'(rr_ptr) + k)]) begin
        win_found = 1'b1;
        win_ch    = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= S_IDLE;
      pending      <= '0;
      rr_ptr       <= CH_W'(NUM_CH - 1);
      cur_ch       <= '0;
      clr_cnt      <= '0;
      gate_cnt     <= '0;
      to_cnt       <= '0;
      ACK          <= '0;
      RESULT       <= '0;
      RESULT_CH    <= '0;
      RESULT_ERR   <= 1'b0;
      RESULT_VALID <= 1'b0;
      ENG_SEL      <= '0;
      ENG_CLR      <= 1'b0;
      ENG_GATE     <= 1'b0;
    end else begin
      // A new REQ landing on the ACK cycle wins, re-queuing the channel.
      pending <= (pending & ~ACK) | REQ;

      case (state)
        S_IDLE: begin
          if (win_found) begin
            cur_ch  <= win_ch;
            ENG_SEL <= win_ch;
            ENG_CLR <= 1'b1;
            rr_ptr  <= win_ch;
            clr_cnt <= CW'(CLR_CYC - 1);
            state   <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (clr_cnt == '0) begin
            ENG_CLR  <= 1'b0;
            ENG_GATE <= 1'b1;
            gate_cnt <= GW'(WINDOW - 1);
            state    <= S_GATE;
          end else begin
            clr_cnt <= clr_cnt - CW'(1);
          end
        end

        S_GATE: begin
          if (gate_cnt == '0) begin
            ENG_GATE <= 1'b0;
            to_cnt   <= TW'(TIMEOUT - 1);
            state    <= S_WAIT;
          end else begin
            gate_cnt <= gate_cnt - GW'(1);
          end
        end

        S_WAIT: begin
          // ENG_DONE is tested first so it beats a coincident timeout.
          if (ENG_DONE || to_cnt == '0) begin
            RESULT       <= ENG_DONE ? ENG_COUNT : 32'hFFFF_FFFF;
            RESULT_ERR   <= ~ENG_DONE;
            RESULT_CH    <= cur_ch;
            RESULT_VALID <= 1'b1;
            // Scan-only measurements have no requester to acknowledge.
            ACK          <= cur_onehot & pending;
            state        <= S_REPORT;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end

        S_REPORT: begin
          RESULT_VALID <= 1'b0;
          ACK          <= '0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_freq_meas_sched.sv
// Bench for aq_freq_meas_sched (default build, no auto scan).
// A transaction-level model predicts, per grant, the cycle windows of
// ENG_CLR / ENG_GATE / REPORT from plain arithmetic, and the grant order from
// a set of pending channels and a round-robin pointer. The engine side is
// driven by the same model (ENG_DONE delay chosen at grant time).
module tb_aq_freq_meas_sched;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int WINDOW  = 100;
  localparam int CLR_CYC = 4;
  localparam int TIMEOUT = 64;
  localparam int NCYC    = 9000;
  localparam int NEVER   = 1000;

  logic              ACLK, ARESETN;
  logic [NUM_CH-1:0] REQ, ACK;
  logic [31:0]       RESULT, ENG_COUNT;
  logic [CH_W-1:0]   RESULT_CH, ENG_SEL;
  logic              RESULT_ERR, RESULT_VALID, BUSY, ENG_CLR, ENG_GATE, ENG_DONE;

  aq_freq_meas_sched #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .WINDOW(WINDOW), .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .REQ(REQ), .ACK(ACK),
    .RESULT(RESULT), .RESULT_CH(RESULT_CH), .RESULT_ERR(RESULT_ERR),
    .RESULT_VALID(RESULT_VALID), .BUSY(BUSY), .ENG_SEL(ENG_SEL),
    .ENG_CLR(ENG_CLR), .ENG_GATE(ENG_GATE), .ENG_DONE(ENG_DONE), .ENG_COUNT(ENG_COUNT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // model state
  int                p, g, r, done_cyc, dly, nmeas;
  bit                has_g, tmo, did_rst, force2, found, idle;
  logic [CH_W-1:0]   ch, rr, sel_exp, rch_exp;
  logic [NUM_CH-1:0] m_pend, req_v, ack_exp;
  logic [31:0]       cnt, res_exp;
  bit                err_exp;
  int                c;

  task automatic model_reset();
    has_g    = 1'b0;
    done_cyc = -1;
    r        = -1;
    g        = -1;
    m_pend   = '0;
    rr       = CH_W'(NUM_CH - 1);
    sel_exp  = '0;
    rch_exp  = '0;
    res_exp  = '0;
    err_exp  = 1'b0;
    ch       = '0;
  endtask

  function automatic bit in_wait(input int q);
    return has_g && q >= g + CLR_CYC + WINDOW + 1 && q < r;
  endfunction

  initial begin
    ARESETN = 1'b0; REQ = '0; ENG_DONE = 1'b0; ENG_COUNT = '0;
    model_reset();
    nmeas = 0; did_rst = 1'b0; force2 = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ctl", {BUSY, ENG_CLR, ENG_GATE, ENG_SEL, RESULT_VALID, ACK}, '0);
    chk("rst_res", {RESULT, RESULT_CH, RESULT_ERR}, '0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;

    p = 0;
    while (p < NCYC) begin
      @(posedge ACLK);
      p++;
      #1;

      // reset in the middle of a gate window
      if (!did_rst && nmeas == 6 && has_g && p == g + CLR_CYC + 50) begin
        did_rst = 1'b1;
        ARESETN = 1'b0;
        #1;
        chk("rst_abort", {ENG_GATE, ENG_CLR, BUSY, RESULT_VALID, ACK}, '0);
        REQ = '0; ENG_DONE = 1'b0;
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        model_reset();
        force2 = 1'b1;
        continue;
      end

      // request stimulus
      req_v = '0;
      if (p == 2)        req_v = 4'b0001;
      else if (p == 20)  req_v = 4'b1110;
      else if (force2) begin req_v = 4'b0100; force2 = 1'b0; end
      else if (p > 600 && $urandom_range(0, 39) == 0) req_v = NUM_CH'($urandom);
      if (has_g && p == r && $urandom_range(0, 2) == 0) req_v[ch] = 1'b1;
      REQ = req_v;

      // engine side
      ENG_DONE  = (p == done_cyc);
      ENG_COUNT = (p == done_cyc) ? cnt : $urandom;
      if (!in_wait(p) && $urandom_range(0, 15) == 0) ENG_DONE = 1'b1;

      @(negedge ACLK);
      if (has_g && p == r) begin
        res_exp = tmo ? 32'hFFFF_FFFF : cnt;
        err_exp = tmo;
        rch_exp = ch;
      end
      if (has_g && p == g + 1) sel_exp = ch;
      ack_exp = (has_g && p == r) ? (NUM_CH'(1) << ch) : '0;
      chk("ctl", {BUSY, ENG_CLR, ENG_GATE, ENG_SEL, RESULT_VALID, ACK},
          {has_g && p > g && p <= r,
           has_g && p >= g + 1 && p <= g + CLR_CYC,
           has_g && p >= g + CLR_CYC + 1 && p <= g + CLR_CYC + WINDOW,
           sel_exp, has_g && p == r, ack_exp});
      chk("res", {RESULT, RESULT_CH, RESULT_ERR}, {res_exp, rch_exp, err_exp});

      // arbitration on the pending set as it stood this cycle
      idle = !(has_g && p > g && p <= r);
      if (idle && m_pend != '0) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
          c = (int'(rr) + k) % NUM_CH;
          if (!found && m_pend[c]) begin
            found = 1'b1;
            ch    = CH_W'(c);
          end
        end
        rr    = ch;
        g     = p;
        has_g = 1'b1;
        nmeas++;
        cnt = $urandom;
        if (nmeas == 1) begin
          dly = 3; cnt = 32'h1234;
        end else if (nmeas == 2) begin
          dly = NEVER;
        end else begin
          case ($urandom_range(0, 9))
            0:       dly = NEVER;
            1:       dly = TIMEOUT;
            2:       dly = TIMEOUT + 1;
            default: dly = $urandom_range(1, TIMEOUT - 1);
          endcase
        end
        tmo      = dly > TIMEOUT;
        done_cyc = (dly == NEVER) ? -1 : g + CLR_CYC + WINDOW + dly;
        r        = g + CLR_CYC + WINDOW + 1 + (tmo ? TIMEOUT : dly);
      end
      m_pend = (m_pend & ~ack_exp) | req_v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aq_freq_meas_sched.md
Name: aq_freq_meas_sched

Overview:
- Round-robin scheduler that shares one frequency-counter engine among NUM_CH measurement requesters.
- For each granted channel it:
  - selects the channel's external clock at the engine,
  - clears the engine counter,
  - opens a counting gate of exactly WINDOW ACLK cycles,
  - waits for the engine's synchronised result,
  - returns the count to the requester.
- Sits between the AXI register slave (request side) and the counter engine.

Parameters:
- NUM_CH, 4, number of requesters / external clocks (2..16).
- CH_W, 2, width of channel index; CH_W = clog2(NUM_CH).
- WINDOW, 100000000, gate length in ACLK cycles (>=2).
- CLR_CYC, 4, cycles ENG_CLR is held for cross-domain clear (>=1).
- TIMEOUT, 64, max ACLK cycles from gate close to ENG_DONE (>=1).

Ports:
- ACLK  in  1  system clock; all logic is on this clock.
- ARESETN  in  1  asynchronous reset, active low.
- REQ  in  NUM_CH  per-channel measurement request pulse (1 cycle).
- ACK  out  NUM_CH  per-channel completion pulse (1 cycle).
- RESULT  out  32  measured count, valid with RESULT_VALID.
- RESULT_CH  out  CH_W  channel the result belongs to.
- RESULT_ERR  out  1  result produced by timeout.
- RESULT_VALID  out  1  one-cycle result strobe.
- BUSY  out  1  high when state != IDLE.
- ENG_SEL  out  CH_W  engine clock-mux select.
- ENG_CLR  out  1  engine counter clear.
- ENG_GATE  out  1  engine count enable.
- ENG_DONE  in  1  engine result-stable pulse (already synchronised to ACLK).
- ENG_COUNT  in  32  engine count, sampled when ENG_DONE is high.
- AUTO_EN  in  1  only present with FREQ_AUTO_SCAN_EN.

Behaviour:
- Reset (async, ARESETN low):
  - state=IDLE; all outputs 0; pending=0.
  - rr_ptr=NUM_CH-1, so channel 0 wins first.
  - Reset mid-measurement aborts immediately; no ACK is issued.
- pending[i] is set by REQ[i] and cleared on ACK[i].
  - If REQ[i] arrives in the same cycle as ACK[i], pending[i] stays set (request re-queued).
  - Repeated REQ while pending is set merges into one request.
- Arbitration (IDLE): search pending from rr_ptr+1 upward, wrapping modulo NUM_CH.
  - On a winner ch: latch ch, ENG_SEL<=ch, ENG_CLR<=1, rr_ptr<=ch, go to CLEAR.
  - A decision is made in every IDLE cycle in which pending != 0.
- CLEAR: hold ENG_CLR for CLR_CYC cycles.
  - Then ENG_CLR<=0, ENG_GATE<=1, gate counter<=WINDOW-1, go to GATE.
- GATE: decrement the counter.
  - ENG_GATE is high for exactly WINDOW cycles.
  - When the counter reaches 0: ENG_GATE<=0, timeout counter<=TIMEOUT-1, go to WAIT.
- WAIT:
  - On ENG_DONE: RESULT<=ENG_COUNT, RESULT_ERR<=0, go to REPORT.
  - If the timeout counter reaches 0 without ENG_DONE: RESULT<=32'hFFFFFFFF, RESULT_ERR<=1, go to REPORT.
  - If ENG_DONE and timeout expiry coincide, ENG_DONE wins.
- REPORT (1 cycle):
  - RESULT_VALID=1, ACK[ch]=1, RESULT_CH=ch; clear pending[ch]; go to IDLE.
  - RESULT, RESULT_CH and RESULT_ERR hold their values until the next REPORT.
- ENG_DONE outside WAIT is ignored.
- ENG_SEL is held stable from the IDLE exit through REPORT; it changes only in IDLE.
- Latency from grant to RESULT_VALID: 1 + CLR_CYC + WINDOW + (cycles to ENG_DONE) + 1.
- No arithmetic on ENG_COUNT: passed through unchanged; 32-bit wrap is the engine's concern.

Optional Feature:
- Macro: FREQ_AUTO_SCAN_EN.
- Defined:
  - AUTO_EN port exists.
  - While AUTO_EN=1, every channel is treated as pending in IDLE, so the block continuously cycles 0,1,..,NUM_CH-1,0,...
  - Each scan result still produces RESULT_VALID; ACK[ch] is pulsed only if pending[ch] was set by a real REQ.
  - Dropping AUTO_EN finishes the current measurement, then the block reverts to request-only operation.
- Not defined: no AUTO_EN port; measurements occur only on REQ.

Test Plan (WINDOW=100, CLR_CYC=4, TIMEOUT=64, NUM_CH=4):
- Reset, REQ[0] pulse, engine returns ENG_DONE 3 cycles after gate close with count 0x1234 -> ENG_CLR high 4 cycles, ENG_GATE high exactly 100 cycles, RESULT=0x1234, RESULT_CH=0, ACK[0] single pulse, RESULT_ERR=0.
- REQ[1], REQ[2], REQ[3] in the same cycle -> measured in order 1,2,3; each ENG_SEL stable for its whole measurement; BUSY high throughout.
- After channel 1 completes, REQ[0] and REQ[1] together -> channel 2-onward ordering is respected: 0 is served before 1 only if rr_ptr wraps; check order 0 then 1 when rr_ptr=3.
- ENG_DONE never asserted -> RESULT=0xFFFFFFFF, RESULT_ERR=1, 64 cycles after gate close.
- ARESETN low during GATE -> ENG_GATE/ENG_CLR/BUSY drop to 0 at once, no ACK, pending cleared; a new REQ[2] afterwards measures normally.
- REQ[0] in the same cycle as ACK[0] -> a second measurement of channel 0 follows immediately.
